// File: rtl/pcpi_pkg.sv
// rtl/pcpi_pkg.sv - shared types and defaults for the PCPI initiator
package pcpi_pkg;

  // Completion status returned with every response.
  typedef enum logic [1:0] {
    PCPI_OK      = 2'd0,
    PCPI_NOWR    = 2'd1,
    PCPI_TIMEOUT = 2'd2,
    PCPI_HANG    = 2'd3
  } pcpi_status_t;

  // Initiator control states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } pcpi_init_state_t;

  localparam int PCPI_TIMEOUT_DEFAULT  = 16;
  localparam int PCPI_MAX_BUSY_DEFAULT = 1024;
  localparam int PCPI_LAT_W_DEFAULT    = 16;

endpackage

// File: rtl/pcpi_initiator.sv
// rtl/pcpi_initiator.sv - host-side master for the PCPI coprocessor bus
module pcpi_initiator
  import pcpi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = PCPI_TIMEOUT_DEFAULT,
  parameter int MAX_BUSY_CYCLES = PCPI_MAX_BUSY_DEFAULT,
  parameter int LAT_W           = PCPI_LAT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_insn,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rd,
  output logic [1:0]       rsp_status,
  output logic [LAT_W-1:0] rsp_latency,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_busy,
  input  logic             pcpi_ready
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  pcpi_init_state_t state_q, state_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rd_q, rsp_rd_d;
  pcpi_status_t     rsp_status_q, rsp_status_d;
  logic [LAT_W-1:0] rsp_latency_q, rsp_latency_d;
  logic             pcpi_valid_q, pcpi_valid_d;
  logic [31:0]      pcpi_insn_q, pcpi_insn_d;
  logic [31:0]      pcpi_rs1_q, pcpi_rs1_d;
  logic [31:0]      pcpi_rs2_q, pcpi_rs2_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

  logic hang_hit;
  logic idle_hit;

  // Both counters count the current ISSUE cycle, so a limit is hit in the
  // cycle whose count equals it.
  assign hang_hit = (lat_cnt_q >= LAT_W'(MAX_BUSY_CYCLES));
  assign idle_hit = (idle_cnt_q >= IDLE_W'(TIMEOUT_CYCLES));

  // State and output registers; reset is asynchronous so an in-flight op is
  // abandoned immediately with no response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_rd_q      <= '0;
      rsp_status_q  <= PCPI_OK;
      rsp_latency_q <= '0;
      pcpi_valid_q  <= 1'b0;
      pcpi_insn_q   <= '0;
      pcpi_rs1_q    <= '0;
      pcpi_rs2_q    <= '0;
      lat_cnt_q     <= '0;
      idle_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_status_q  <= rsp_status_d;
      rsp_latency_q <= rsp_latency_d;
      pcpi_valid_q  <= pcpi_valid_d;
      pcpi_insn_q   <= pcpi_insn_d;
      pcpi_rs1_q    <= pcpi_rs1_d;
      pcpi_rs2_q    <= pcpi_rs2_d;
      lat_cnt_q     <= lat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
    end
  end

  // Next-state and registered-output logic for IDLE -> ISSUE -> RESP.
  always_comb begin
    state_d       = state_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_status_d  = rsp_status_q;
    rsp_latency_d = rsp_latency_q;
    pcpi_valid_d  = pcpi_valid_q;
    pcpi_insn_d   = pcpi_insn_q;
    pcpi_rs1_d    = pcpi_rs1_q;
    pcpi_rs2_d    = pcpi_rs2_q;
    lat_cnt_d     = lat_cnt_q;
    idle_cnt_d    = idle_cnt_q;

    case (state_q)
      ST_IDLE: begin
        // pcpi_ready seen here is stale or spurious and deliberately ignored.
        if (req_valid) begin
          pcpi_insn_d  = req_insn;
          pcpi_rs1_d   = req_rs1;
          pcpi_rs2_d   = req_rs2;
          pcpi_valid_d = 1'b1;
          req_ready_d  = 1'b0;
          lat_cnt_d    = LAT_W'(1);
          idle_cnt_d   = IDLE_W'(1);
          state_d      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (pcpi_ready) begin
          rsp_rd_d      = pcpi_wr ? pcpi_rd : 32'h0;
          rsp_status_d  = pcpi_wr ? PCPI_OK : PCPI_NOWR;
          rsp_latency_d = lat_cnt_q;
          rsp_valid_d   = 1'b1;
          pcpi_valid_d  = 1'b0;
          state_d       = ST_RESP;
        end else if (hang_hit) begin
          rsp_rd_d      = 32'h0;
          rsp_status_d  = PCPI_HANG;
          rsp_latency_d = lat_cnt_q;
          rsp_valid_d   = 1'b1;
          pcpi_valid_d  = 1'b0;
          state_d       = ST_RESP;
        end else if (idle_hit) begin
          rsp_rd_d      = 32'h0;
          rsp_status_d  = PCPI_TIMEOUT;
          rsp_latency_d = lat_cnt_q;
          rsp_valid_d   = 1'b1;
          pcpi_valid_d  = 1'b0;
          state_d       = ST_RESP;
        end else begin
          if (lat_cnt_q != '1) begin
            lat_cnt_d = lat_cnt_q + LAT_W'(1);
          end
          // A busy coprocessor is making progress; only unclaimed cycles count
          // toward the timeout.
          if (pcpi_busy) begin
            idle_cnt_d = '0;
          end else begin
            idle_cnt_d = idle_cnt_q + IDLE_W'(1);
          end
        end
      end

      ST_RESP: begin
        // The handshake cycle never accepts a request, which keeps pcpi_valid
        // low for at least two cycles between ops.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_latency = rsp_latency_q;
  assign pcpi_valid  = pcpi_valid_q;
  assign pcpi_insn   = pcpi_insn_q;
  assign pcpi_rs1    = pcpi_rs1_q;
  assign pcpi_rs2    = pcpi_rs2_q;

endmodule
